// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline stall/flush controller with optional perf counters.
// Macro PIPE_CTRL_PERF_EN enables stall_cnt/flush_cnt. Ports: cache status, hazard info, br_taken in; load_*/nop_* enables and counters out.
module pipe_ctrl #(
  parameter int REGW = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            icache_resp,
  input  logic            dcache_req,
  input  logic            dcache_resp,
  input  logic            ex_is_load,
  input  logic [REGW-1:0] ex_dest,
  input  logic [REGW-1:0] id_src1,
  input  logic [REGW-1:0] id_src2,
  input  logic [1:0]      id_src_vld,
  input  logic            br_taken,
  output logic            load_pc,
  output logic            load_if_id,
  output logic            load_id_ex,
  output logic            load_ex_mem,
  output logic            load_mem_wb,
  output logic            nop_if_id,
  output logic            nop_id_ex,
  output logic            nop_ex_mem,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   dstall, luh, istall;

  assign dstall = dcache_req & ~dcache_resp;
  assign istall = ~icache_resp;
  assign luh    = ex_is_load &
                  ((id_src_vld[0] & (id_src1 == ex_dest)) |
                   (id_src_vld[1] & (id_src2 == ex_dest)));

  always_comb begin
    load_pc     = 1'b1;
    load_if_id  = 1'b1;
    load_id_ex  = 1'b1;
    load_ex_mem = 1'b1;
    load_mem_wb = 1'b1;
    nop_if_id   = 1'b0;
    nop_id_ex   = 1'b0;
    nop_ex_mem  = 1'b0;
    state_d     = state_q;
    if (!rst_n) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      nop_if_id   = 1'b1;
      nop_id_ex   = 1'b1;
      nop_ex_mem  = 1'b1;
    end else if (dstall) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (br_taken) begin
      nop_if_id  = 1'b1;
      nop_id_ex  = 1'b1;
      nop_ex_mem = 1'b1;
      // an outstanding fetch (new or old wrong-path) must be drained
      if (istall || state_q == DRAIN) state_d = DRAIN;
      else                            state_d = RUN;
    end else if (luh) begin
      load_pc    = 1'b0;
      load_if_id = 1'b0;
      nop_id_ex  = 1'b1;
      // keep tracking the wrong-path fetch underneath the hazard stall
      if (state_q == DRAIN && icache_resp) state_d = RUN;
    end else if (state_q == DRAIN) begin
      load_pc   = 1'b0;
      nop_if_id = 1'b1;
      if (icache_resp) state_d = RUN;
    end else if (istall) begin
      load_pc   = 1'b0;
      nop_if_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNTW-1:0] stall_cnt_q, flush_cnt_q;
  logic            flush_ev;

  assign flush_ev = ~dstall & br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!load_pc && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      if (flush_ev && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNTW'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + random stimulus against an action-level model.
// Counter expectations follow PIPE_CTRL_PERF_EN; CNTW is shrunk so saturation is reached.
module tb_pipe_ctrl;

  localparam int REGW = 3;
  localparam int CNTW = 6;
  localparam int CMAX = (1 << CNTW) - 1;

  // {load_pc,load_if_id,load_id_ex,load_ex_mem,load_mem_wb,nop_if_id,nop_id_ex,nop_ex_mem}
  localparam logic [7:0] A_RESET  = 8'b00000_111;
  localparam logic [7:0] A_FREEZE = 8'b00000_000;
  localparam logic [7:0] A_FLUSH  = 8'b11111_111;
  localparam logic [7:0] A_HOLD   = 8'b00111_010;
  localparam logic [7:0] A_BUBBLE = 8'b01111_100;
  localparam logic [7:0] A_FLOW   = 8'b11111_000;

  logic clk = 1'b0;
  logic rst_n;
  logic icache_resp, dcache_req, dcache_resp, ex_is_load, br_taken;
  logic [REGW-1:0] ex_dest, id_src1, id_src2;
  logic [1:0] id_src_vld;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic nop_if_id, nop_id_ex, nop_ex_mem;
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // model: is a wrong-path fetch still outstanding, and event tallies
  bit m_pend;
  int m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_resp(icache_resp),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src_vld(id_src_vld), .br_taken(br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
    .load_mem_wb(load_mem_wb),
    .nop_if_id(nop_if_id), .nop_id_ex(nop_id_ex),
    .nop_ex_mem(nop_ex_mem),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [7:0] outs();
    return {load_pc, load_if_id, load_id_ex, load_ex_mem,
            load_mem_wb, nop_if_id, nop_id_ex, nop_ex_mem};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk_cnt(input string tag);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(sat(m_stall)));
    chk({tag, "_flush"}, 32'(flush_cnt), 32'(sat(m_flush)));
`else
    chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_flush"}, 32'(flush_cnt), 32'd0);
`endif
  endtask

  // one cycle: drive at posedge+1, check outputs at negedge, advance model
  task automatic step(input string tag, input logic dreq, dresp, ic,
                      input logic ld, input logic [REGW-1:0] dst, s1, s2,
                      input logic [1:0] vld, input logic br);
    logic [7:0] act;
    bit hz;
    dcache_req = dreq; dcache_resp = dresp; icache_resp = ic;
    ex_is_load = ld; ex_dest = dst; id_src1 = s1; id_src2 = s2;
    id_src_vld = vld; br_taken = br;
    #4;
    hz = ld && ((vld[0] && s1 == dst) || (vld[1] && s2 == dst));
    if (dreq && !dresp)      act = A_FREEZE;
    else if (br)             act = A_FLUSH;
    else if (hz)             act = A_HOLD;
    else if (!ic || m_pend)  act = A_BUBBLE;
    else                     act = A_FLOW;
    chk({tag, "_outs"}, 32'(outs()), 32'(act));
    if (act == A_FLUSH) begin
      m_flush++;
      m_pend = m_pend || !ic;
    end else if (act != A_FREEZE && ic) begin
      m_pend = 1'b0;
    end
    if (act == A_FREEZE || act == A_HOLD || act == A_BUBBLE) m_stall++;
    @(posedge clk); #1;
    chk_cnt(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_outs"}, 32'(outs()), 32'(A_RESET));
    m_pend = 1'b0; m_stall = 0; m_flush = 0;
    chk_cnt({tag, "_rst"});
    @(posedge clk); #1;
    chk({tag, "_rst_hold"}, 32'(outs()), 32'(A_RESET));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    icache_resp = 1'b0; dcache_req = 1'b0; dcache_resp = 1'b0;
    ex_is_load = 1'b0; br_taken = 1'b0;
    ex_dest = '0; id_src1 = '0; id_src2 = '0; id_src_vld = '0;
    m_pend = 1'b0; m_stall = 0; m_flush = 0;
    #2;
    chk("por_outs", 32'(outs()), 32'(A_RESET));
    chk_cnt("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++)
      step("idle", 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++)
      step("dstall", 1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    step("dresp", 1, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    step("luh", 0, 0, 1, 1, 3'd3, 3'd1, 3'd3, 2'b10, 0);
    step("noluh", 0, 0, 1, 1, 3'd3, 3'd1, 3'd3, 2'b00, 0);
    step("br_miss", 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step("drain1", 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step("drain2", 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    step("after_drain", 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    step("frz_br1", 1, 0, 1, 0, 0, 0, 0, 2'b00, 1);
    step("frz_br2", 1, 0, 1, 0, 0, 0, 0, 2'b00, 1);
    step("br_late", 0, 0, 1, 0, 0, 0, 0, 2'b00, 1);
    step("luh_istall", 0, 0, 0, 1, 3'd5, 3'd5, 3'd0, 2'b01, 0);
    step("br_ic1", 0, 0, 1, 0, 0, 0, 0, 2'b00, 1);
    step("br_to_drain", 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    pulse_reset("mid_drain");
    step("post_rst", 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);

    for (int i = 0; i < 700; i++) begin
      step("rnd",
           ($urandom_range(99) < 30), ($urandom_range(99) < 50),
           ($urandom_range(99) < 65), ($urandom_range(99) < 50),
           REGW'($urandom), REGW'($urandom), REGW'($urandom),
           2'($urandom), ($urandom_range(99) < 15));
      if (i == 350) pulse_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: REGW, 3, register-specifier width for hazard compare.
REQ-002 Parameter: CNTW, 16, performance counter width.
REQ-003 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all state on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- icache_resp  in  1  fetch for current PC complete this cycle.
- dcache_req  in  1  MEM stage holds a memory access.
- dcache_resp  in  1  MEM access completes this cycle.
- ex_is_load  in  1  EX stage instruction is a load.
- ex_dest  in  REGW  EX stage destination register.
- id_src1, id_src2  in  REGW each  ID stage source registers.
- id_src_vld  in  2  bit0 = id_src1 used, bit1 = id_src2 used.
- br_taken  in  1  MEM stage resolved taken branch/jump.
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage-register load enables.
- nop_if_id, nop_id_ex, nop_ex_mem  out  1 each  when loading, write a bubble instead of the upstream value.
- stall_cnt  out  CNTW  stall cycle count.
- flush_cnt  out  CNTW  flush event count.

Function
REQ-004 States: RUN, DRAIN; outputs are combinational from state and inputs.
REQ-005 Conditions: dstall = dcache_req & ~dcache_resp. luh = ex_is_load & ((id_src_vld[0] & id_src1==ex_dest) | (id_src_vld[1] & id_src2==ex_dest)). istall = ~icache_resp.
REQ-006 Priority, highest first: dstall, br_taken, luh, istall/DRAIN.
REQ-007 dstall: all five load_* = 0 and all nop_* = 0; the whole pipe freezes; the state is held.
REQ-008 br_taken (no dstall): all load_* = 1; nop_if_id = nop_id_ex = nop_ex_mem = 1; the PC takes the redirect target.
REQ-009 br_taken with icache_resp = 0 or state DRAIN: next state DRAIN; otherwise next state RUN.
REQ-010 luh (no dstall, no br_taken): load_pc = 0, load_if_id = 0, load_id_ex = 1 with nop_id_ex = 1, load_ex_mem = load_mem_wb = 1.
REQ-011 istall in RUN (no higher condition): load_pc = 0, load_if_id = 1 with nop_if_id = 1, downstream loads = 1.
REQ-012 DRAIN (no higher condition): the wrong-path fetch is in flight.
- load_pc = 0; load_if_id = 1 with nop_if_id = 1, regardless of icache_resp; downstream loads = 1.
- icache_resp = 1 in DRAIN: next state RUN; the returned word is discarded.
REQ-013 RUN with no condition active: all load_* = 1, all nop_* = 0.
REQ-014 luh combined with istall: the luh outputs apply; there is no bubble into IF/ID.
REQ-015 Simultaneous dstall and br_taken: the freeze wins; br_taken is acted on in the first cycle in which dstall = 0.

Reset
REQ-016 rst_n = 0 forces the state to RUN and stall_cnt = flush_cnt = 0 asynchronously.
REQ-017 While rst_n = 0, all load_* = 0 and all nop_* = 1.
REQ-018 Deassertion of rst_n in the middle of a DRAIN returns the block to RUN; a pending wrong-path response is not tracked after reset.

Configuration
REQ-019 Macro PIPE_CTRL_PERF_EN defined:
- stall_cnt increments on every cycle with load_pc = 0 outside reset.
- flush_cnt increments on every cycle in which REQ-008 applies.
- both counters saturate at all-ones.
REQ-020 Macro PIPE_CTRL_PERF_EN undefined: stall_cnt = flush_cnt = 0 constant; no counter flops are synthesized.

Verification
REQ-021 Idle RUN, icache_resp = 1, no hazards -> all load_* = 1 and all nop_* = 0 every cycle.
REQ-022 dcache_req = 1, dcache_resp low for 3 cycles -> all loads = 0 for 3 cycles, all loads = 1 on the resp cycle; stall_cnt = 3 with the macro defined.
REQ-023 ex_is_load = 1, ex_dest = 3, id_src2 = 3, id_src_vld = 2'b10 -> load_pc = 0, load_if_id = 0, nop_id_ex = 1 for 1 cycle; id_src_vld = 0 -> no stall.
REQ-024 br_taken with icache_resp = 0 -> flush outputs; DRAIN for 2 cycles until icache_resp = 1, nop_if_id = 1 throughout, then RUN; flush_cnt = 1.
REQ-025 dstall and br_taken together for 2 cycles, then dstall drops -> frozen 2 cycles, flush on cycle 3.
REQ-026 rst_n pulsed low in DRAIN -> load_* = 0 and nop_* = 1 immediately; RUN and counters = 0 after release.
